// File: rtl/riscv_regfile_wb_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
// Holds the data width, register-address width and writeback port indices.
package riscv_regfile_wb_ctrl_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_AW     = 5;
   localparam int unsigned NUM_REGS   = 1 << REG_AW;

   localparam int unsigned WB_PORT_ALU = 0;
   localparam int unsigned WB_PORT_LSU = 1;

   // Which port won the most recent transfer; the other port wins the next tie.
   typedef enum logic {
      LAST_P0 = 1'b0,
      LAST_P1 = 1'b1
   } rr_last_e;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational.
// The last-grant pointer advances only on a grant.
module riscv_rr_arb2
   import riscv_regfile_wb_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   rr_last_e last_q;
   rr_last_e last_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= LAST_P1;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      last_d = last_q;
      if (!rst) begin
         if (req0 && (!req1 || (last_q == LAST_P1))) begin
            gnt0 = 1'b1;
         end else if (req1) begin
            gnt1 = 1'b1;
         end
      end
      if (gnt0) begin
         last_d = LAST_P0;
      end else if (gnt1) begin
         last_d = LAST_P1;
      end
   end

endmodule

// File: rtl/riscv_regfile_wb_ctrl.sv
// Writeback controller: arbitrates two writeback ports onto the single
// register-file write port and tracks pending destinations for hazard checks.
module riscv_regfile_wb_ctrl
   import riscv_regfile_wb_ctrl_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wb0_valid,
   output logic              o_wb0_ready,
   input  logic [REG_AW-1:0] i_wb0_addr,
   input  logic [XLEN-1:0]   i_wb0_data,
   input  logic              i_wb1_valid,
   output logic              o_wb1_ready,
   input  logic [REG_AW-1:0] i_wb1_addr,
   input  logic [XLEN-1:0]   i_wb1_data,
   output logic              o_regfile_rd_wen,
   output logic [REG_AW-1:0] o_regfile_rd_addr,
   output logic [XLEN-1:0]   o_regfile_rd_data,
   input  logic              i_alloc_valid,
   input  logic [REG_AW-1:0] i_alloc_addr,
   output logic              o_alloc_ready,
   input  logic [REG_AW-1:0] i_rs1_addr,
   input  logic [REG_AW-1:0] i_rs2_addr,
   output logic              o_rs1_busy,
   output logic              o_rs2_busy,
   output logic              o_idle
);

   logic                gnt0;
   logic                gnt1;
   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic                wen_q;
   logic [REG_AW-1:0]   addr_q;
   logic [XLEN-1:0]     data_q;
   logic                alloc_fire;
   logic [REG_AW-1:0]   xfer_addr;
   logic [XLEN-1:0]     xfer_data;

   riscv_rr_arb2 u_arb (
      .clk  (i_clk),
      .rst  (i_rst),
      .req0 (i_wb0_valid),
      .req1 (i_wb1_valid),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   assign o_wb0_ready = gnt0;
   assign o_wb1_ready = gnt1;
   assign xfer_addr   = gnt1 ? i_wb1_addr : i_wb0_addr;
   assign xfer_data   = gnt1 ? i_wb1_data : i_wb0_data;

   assign o_alloc_ready = !i_rst && ((i_alloc_addr == '0) || !pending_q[i_alloc_addr]);
   assign alloc_fire    = i_alloc_valid && o_alloc_ready && (i_alloc_addr != '0);

   assign o_rs1_busy = (i_rs1_addr != '0) && pending_q[i_rs1_addr];
   assign o_rs2_busy = (i_rs2_addr != '0) && pending_q[i_rs2_addr];

   // Clear first so a same-cycle reservation of the written address survives.
   always_comb begin
      pending_d = pending_q;
      if (wen_q) begin
         pending_d[addr_q] = 1'b0;
      end
      if (alloc_fire) begin
         pending_d[i_alloc_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pending_q <= '0;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         pending_q <= pending_d;
         wen_q     <= 1'b0;
         if (gnt0 || gnt1) begin
            wen_q  <= (xfer_addr != '0);
            addr_q <= xfer_addr;
            data_q <= xfer_data;
         end
      end
   end

   assign o_regfile_rd_wen  = wen_q;
   assign o_regfile_rd_addr = addr_q;
   assign o_regfile_rd_data = data_q;
   assign o_idle            = (pending_q == '0) && !wen_q;

endmodule

// File: tb/tb_riscv_regfile_wb_ctrl.sv
// Randomized bench for riscv_regfile_wb_ctrl against a behavioural model
// built from the arbitration, write-stage and scoreboard rules.
module tb_riscv_regfile_wb_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_wb0_valid, i_wb1_valid;
   logic        o_wb0_ready, o_wb1_ready;
   logic [4:0]  i_wb0_addr, i_wb1_addr;
   logic [31:0] i_wb0_data, i_wb1_data;
   logic        o_regfile_rd_wen;
   logic [4:0]  o_regfile_rd_addr;
   logic [31:0] o_regfile_rd_data;
   logic        i_alloc_valid;
   logic [4:0]  i_alloc_addr;
   logic        o_alloc_ready;
   logic [4:0]  i_rs1_addr, i_rs2_addr;
   logic        o_rs1_busy, o_rs2_busy;
   logic        o_idle;

   riscv_regfile_wb_ctrl dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_wb0_valid       (i_wb0_valid),
      .o_wb0_ready       (o_wb0_ready),
      .i_wb0_addr        (i_wb0_addr),
      .i_wb0_data        (i_wb0_data),
      .i_wb1_valid       (i_wb1_valid),
      .o_wb1_ready       (o_wb1_ready),
      .i_wb1_addr        (i_wb1_addr),
      .i_wb1_data        (i_wb1_data),
      .o_regfile_rd_wen  (o_regfile_rd_wen),
      .o_regfile_rd_addr (o_regfile_rd_addr),
      .o_regfile_rd_data (o_regfile_rd_data),
      .i_alloc_valid     (i_alloc_valid),
      .i_alloc_addr      (i_alloc_addr),
      .o_alloc_ready     (o_alloc_ready),
      .i_rs1_addr        (i_rs1_addr),
      .i_rs2_addr        (i_rs2_addr),
      .o_rs1_busy        (o_rs1_busy),
      .o_rs2_busy        (o_rs2_busy),
      .o_idle            (o_idle)
   );

   always #5 i_clk = ~i_clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference state: the set of reserved registers, who won last, and what
   // the register file is being handed this cycle.
   bit          pend [32];
   int          last_winner;
   bit          st_wen;
   bit [4:0]    st_addr;
   bit [31:0]   st_data;

   function automatic bit model_idle();
      for (int r = 0; r < 32; r++) if (pend[r]) return 1'b0;
      return !st_wen;
   endfunction

   initial begin
      int winner;
      bit any_pend;
      bit [4:0]  w_addr;
      bit [31:0] w_data;

      i_rst = 1'b1;
      i_wb0_valid = 1'b0; i_wb1_valid = 1'b0;
      i_wb0_addr = '0; i_wb1_addr = '0;
      i_wb0_data = '0; i_wb1_data = '0;
      i_alloc_valid = 1'b0; i_alloc_addr = '0;
      i_rs1_addr = '0; i_rs2_addr = '0;

      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
      last_winner = 1;
      st_wen = 1'b0; st_addr = '0; st_data = '0;

      @(posedge i_clk);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge i_clk);

         check("rd_wen",  {31'b0, o_regfile_rd_wen}, {31'b0, st_wen});
         check("rd_addr", {27'b0, o_regfile_rd_addr}, {27'b0, st_addr});
         check("rd_data", o_regfile_rd_data, st_data);
         check("idle",    {31'b0, o_idle}, {31'b0, model_idle()});

         // Requesters keep an unaccepted request unchanged; otherwise draw anew.
         i_rst = (cyc < 3) || ($urandom_range(0, 199) == 0);
         if (!i_wb0_valid) begin
            i_wb0_valid = ($urandom_range(0, 3) != 0);
            i_wb0_addr  = 5'($urandom_range(0, 9));
            i_wb0_data  = $urandom;
         end
         if (!i_wb1_valid) begin
            i_wb1_valid = ($urandom_range(0, 3) != 0);
            i_wb1_addr  = 5'($urandom_range(0, 9));
            i_wb1_data  = $urandom;
         end
         i_alloc_valid = ($urandom_range(0, 1) != 0);
         i_alloc_addr  = 5'($urandom_range(0, 9));
         i_rs1_addr    = 5'($urandom_range(0, 9));
         i_rs2_addr    = 5'($urandom_range(0, 9));

         #1;
         winner = -1;
         if (!i_rst) begin
            if (i_wb0_valid && i_wb1_valid) winner = 1 - last_winner;
            else if (i_wb0_valid)           winner = 0;
            else if (i_wb1_valid)           winner = 1;
         end

         check("wb0_ready",   {31'b0, o_wb0_ready}, {31'b0, (winner == 0)});
         check("wb1_ready",   {31'b0, o_wb1_ready}, {31'b0, (winner == 1)});
         check("alloc_ready", {31'b0, o_alloc_ready},
               {31'b0, (!i_rst && (i_alloc_addr == 0 || !pend[i_alloc_addr]))});
         check("rs1_busy",    {31'b0, o_rs1_busy}, {31'b0, (i_rs1_addr != 0 && pend[i_rs1_addr])});
         check("rs2_busy",    {31'b0, o_rs2_busy}, {31'b0, (i_rs2_addr != 0 && pend[i_rs2_addr])});

         // Advance the model to what the coming clock edge should produce.
         if (i_rst) begin
            for (int r = 0; r < 32; r++) pend[r] = 1'b0;
            last_winner = 1;
            st_wen = 1'b0; st_addr = '0; st_data = '0;
         end else begin
            any_pend = (i_alloc_addr != 0) && pend[i_alloc_addr];
            if (st_wen) pend[st_addr] = 1'b0;
            if (i_alloc_valid && !any_pend && i_alloc_addr != 0) pend[i_alloc_addr] = 1'b1;
            if (winner >= 0) begin
               w_addr = (winner == 0) ? i_wb0_addr : i_wb1_addr;
               w_data = (winner == 0) ? i_wb0_data : i_wb1_data;
               last_winner = winner;
               st_wen  = (w_addr != 0);
               st_addr = w_addr;
               st_data = w_data;
            end else begin
               st_wen = 1'b0;
            end
         end

         @(posedge i_clk);
         #1;
         if (winner == 0) i_wb0_valid = 1'b0;
         if (winner == 1) i_wb1_valid = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
